arm_dp_sequencer: RTL and testbench
===================================

// Module: arm_dp_sequencer
// PURPOSE
//  Multi-cycle controller that executes one ARM data-processing instruction at a time on the shared ARM_ALU.
//  Handshakes instructions in, reads register operands, and decodes the operation into ALU OP/S/ALU_OUT.
//  Writes back the result and holds the CPSR NZCV flags. Sits between fetch/decode and the regfile+ALU datapath.
// PARAMETERS
//  DW      32  datapath width (ALU is fixed at 32; kept for bench reuse)
//  RF_AW   4   register file address width (r0..r15)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   synchronous, active-high
//  instr_valid   in   1   instr present
//  instr_ready   out  1   sequencer can accept (IDLE only)
//  instr         in   32  ARM data-processing word
//  rf_ra_addr    out  4   regfile read port A (Rn)
//  rf_rb_addr    out  4   regfile read port B (Rm)
//  rf_a_data     in   32  Rn data, valid 1 cycle after address (sync read)
//  rf_b_data     in   32  Rm data, same timing
//  alu_a         out  32  ALU A operand
//  alu_b         out  32  ALU B operand (Rm or rotated imm)
//  alu_op        out  5   ALU OP
//  alu_s         out  1   ALU S (flag update enable)
//  alu_out_en    out  1   ALU_OUT; ALU drives Out only while high
//  alu_flags     out  4   CPSR fed to ALU FLAGS {N,Z,C,V}
//  alu_result    in   32  ALU Out
//  alu_flags_out in   4   ALU FLAGS_OUT
//  rf_we         out  1   regfile write strobe
//  rf_waddr      out  4   Rd
//  rf_wdata      out  32  result
//  cpsr_flags    out  4   architectural NZCV {N=3,Z=2,C=1,V=0}
//  done          out  1   1-cycle pulse: instruction retired or skipped
//  illegal       out  1   1-cycle pulse: unsupported encoding, no side effects
// BEHAVIOUR
//  Reset: state IDLE; cpsr_flags=0; all other outputs 0 except instr_ready=1 the cycle after reset drops.
//  Reset mid-instruction aborts it: no rf_we, no flag commit, no done.
//  FSM IDLE->READ->EXEC->WB->IDLE. Accept when instr_valid&&instr_ready; latch instr; ready=0 until back in IDLE.
//  READ (cyc1): drive rf_ra_addr=instr[19:16], rf_rb_addr=instr[3:0]; evaluate cond instr[31:28] vs cpsr_flags.
//   Cond fail or cond=1111 -> done pulse, ->IDLE.
//   instr[27:26]!=00, or I=0 with instr[11:4]!=0 (shifted reg), or Rd=15 on a writing op -> illegal pulse, ->IDLE.
//  EXEC (cyc2): alu_a=rf_a_data, alu_b=I?ror({24'b0,imm8},2*rot):rf_b_data; alu_out_en=1.
//   alu_op={1'b0,opc} except MOV(1101)->5'b10000.
//   alu_s=instr[20] | (opc in 1000..1011). Capture alu_result and alu_flags_out into regs at end of cycle.
//  WB (cyc3): rf_we=1 unless opc in TST/TEQ/CMP/CMN; rf_waddr=instr[15:12]; rf_wdata=captured result.
//   If S effective: cpsr_flags<=captured flags, except logical ops (AND,EOR,TST,TEQ,ORR,MOV,BIC,MVN) keep old C,V.
//   done=1.
//  Latency: accept at cycle 0, rf_we/done at cycle 3; throughput 1 instr / 4 cycles. Back-to-back: instr_ready high in the WB+1 cycle.
//  Flags written in WB are visible to cond check of next instr (bypass not needed: next READ is >=1 cycle later).
//  alu_out_en=0 outside EXEC; alu_a/alu_b/alu_op hold 0 outside EXEC.
//  Rotation: rot=instr[11:8], amount 2*rot in 0..30, rot=0 -> imm8 unchanged.
//  instr_valid while busy is ignored (held by producer). X on unused inputs must not affect outputs.
// STRUCTURE
//  Package arm_dp_pkg: state enum, 4-bit ARM opcode constants, cond-code constants, ALU OP constants (incl. BYPASS 10000), flag index localparams N/Z/C/V.
//  Sub-module arm_cond_check: combinational cond[3:0] x NZCV -> pass (all 15 ARM codes, NV=fail).
// TESTING
//  ADDS r2,r0,r1 (E0902001), r0=7FFFFFFF, r1=1 -> rf_we cyc3, r2=80000000, cpsr N=1 Z=0 C=0 V=1.
//  CMP r0,#5 (E3500005), r0=5 -> no rf_we, Z=1, done cyc3; following MOVNE r3,#1 (13A03001) -> done cyc1, no write.
//  MOV r4,#0xFF000000 (E3A044FF) -> r4=FF000000, flags unchanged (S=0).
//  ANDS after C=1,V=1 with result 0 -> Z=1, C=1, V=1 preserved.
//  ADD r1,r2,r3,LSL #2 (E0821103) -> illegal pulse cyc1, no rf_we, flags unchanged; LDR word -> illegal.
//  Reset asserted in EXEC of ADDS -> no rf_we, cpsr=0, instr_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/arm_dp_sequencer_pkg.sv
// Shared types and constants for the ARM data-processing sequencer:
// FSM states, opcode/condition encodings, ALU op codes and decode helpers.
package arm_dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    localparam logic [3:0] OPC_AND = 4'h0;
    localparam logic [3:0] OPC_EOR = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_RSB = 4'h3;
    localparam logic [3:0] OPC_ADD = 4'h4;
    localparam logic [3:0] OPC_ADC = 4'h5;
    localparam logic [3:0] OPC_SBC = 4'h6;
    localparam logic [3:0] OPC_RSC = 4'h7;
    localparam logic [3:0] OPC_TST = 4'h8;
    localparam logic [3:0] OPC_TEQ = 4'h9;
    localparam logic [3:0] OPC_CMP = 4'hA;
    localparam logic [3:0] OPC_CMN = 4'hB;
    localparam logic [3:0] OPC_ORR = 4'hC;
    localparam logic [3:0] OPC_MOV = 4'hD;
    localparam logic [3:0] OPC_BIC = 4'hE;
    localparam logic [3:0] OPC_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [4:0] ALU_OP_BYPASS = 5'b10000;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic is_logical(input logic [3:0] opc);
        return opc inside {OPC_AND, OPC_EOR, OPC_TST, OPC_TEQ,
                           OPC_ORR, OPC_MOV, OPC_BIC, OPC_MVN};
    endfunction

    function automatic logic writes_rd(input logic [3:0] opc);
        return !(opc inside {OPC_TST, OPC_TEQ, OPC_CMP, OPC_CMN});
    endfunction

    // Rotated 8-bit immediate: ror by 2*rot, done as a shift of a doubled copy.
    function automatic logic [31:0] ror_imm(input logic [11:0] f);
        logic [63:0] d;
        d = {24'b0, f[7:0], 24'b0, f[7:0]};
        d = d >> {f[11:8], 1'b0};
        return d[31:0];
    endfunction

endpackage

// File: rtl/arm_dp_sequencer_if.sv
// Bundle of instruction handshake, regfile and ALU signals around the sequencer.
// slave = the sequencer itself, master = fetch/decode + regfile + ALU side.
interface arm_dp_sequencer_if #(
    parameter int DW    = 32,
    parameter int RF_AW = 4
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [RF_AW-1:0] rf_ra_addr;
    logic [RF_AW-1:0] rf_rb_addr;
    logic [DW-1:0]    rf_a_data;
    logic [DW-1:0]    rf_b_data;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic [4:0]       alu_op;
    logic             alu_s;
    logic             alu_out_en;
    logic [3:0]       alu_flags;
    logic [DW-1:0]    alu_result;
    logic [3:0]       alu_flags_out;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [3:0]       cpsr_flags;
    logic             done;
    logic             illegal;

    modport slave (
        input  instr_valid, instr, rf_a_data, rf_b_data, alu_result, alu_flags_out,
        output instr_ready, rf_ra_addr, rf_rb_addr, alu_a, alu_b, alu_op, alu_s,
               alu_out_en, alu_flags, rf_we, rf_waddr, rf_wdata, cpsr_flags,
               done, illegal
    );

    modport master (
        output instr_valid, instr, rf_a_data, rf_b_data, alu_result, alu_flags_out,
        input  instr_ready, rf_ra_addr, rf_rb_addr, alu_a, alu_b, alu_op, alu_s,
               alu_out_en, alu_flags, rf_we, rf_waddr, rf_wdata, cpsr_flags,
               done, illegal
    );
endinterface

// File: rtl/arm_dp_sequencer_cond.sv
// ARM condition-code evaluator: cond[3:0] against NZCV, NV never passes.
module arm_cond_check
    import arm_dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_dp_sequencer.sv
// Four-state controller running one ARM data-processing instruction at a time
// through the shared ALU: IDLE -> READ -> EXEC -> WB, holding the CPSR NZCV flags.
module arm_dp_sequencer
    import arm_dp_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RF_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    arm_dp_sequencer_if.slave  bus
);
    state_t           state_q, state_d;
    logic [31:0]      instr_q;
    logic [DW-1:0]    res_q;
    logic [3:0]       flg_q;
    logic [3:0]       cpsr_q;

    logic [3:0]       cond, opc;
    logic             i_bit, s_bit, s_eff, cond_pass, illegal_enc;
    logic [RF_AW-1:0] rn, rd, rm;
    logic [31:0]      op_b;

    assign cond  = instr_q[31:28];
    assign i_bit = instr_q[25];
    assign opc   = instr_q[24:21];
    assign s_bit = instr_q[20];
    assign rn    = instr_q[19:16];
    assign rd    = instr_q[15:12];
    assign rm    = instr_q[3:0];

    // Compare-class opcodes always update flags, even with S clear.
    assign s_eff = s_bit || (opc[3:2] == 2'b10);

    assign illegal_enc = (instr_q[27:26] != 2'b00)
                      || (!i_bit && (instr_q[11:4] != 8'h00))
                      || ((rd == 4'hF) && writes_rd(opc));

    assign op_b = i_bit ? ror_imm(instr_q[11:0]) : bus.rf_b_data;

    assign bus.cpsr_flags = cpsr_q;
    assign bus.alu_flags  = cpsr_q;

    arm_cond_check u_cond (
        .cond  (cond),
        .flags (cpsr_q),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            cpsr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.instr_valid) begin
                instr_q <= bus.instr;
            end
            if (state_q == ST_EXEC) begin
                res_q <= bus.alu_result;
                flg_q <= bus.alu_flags_out;
            end
            // Logical ops take N/Z from the ALU but keep the architectural C/V.
            if (state_q == ST_WB && s_eff) begin
                if (is_logical(opc)) begin
                    cpsr_q <= {flg_q[FLAG_N], flg_q[FLAG_Z], cpsr_q[FLAG_C], cpsr_q[FLAG_V]};
                end else begin
                    cpsr_q <= flg_q;
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.rf_ra_addr  = '0;
        bus.rf_rb_addr  = '0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_op      = '0;
        bus.alu_s       = 1'b0;
        bus.alu_out_en  = 1'b0;
        bus.rf_we       = 1'b0;
        bus.rf_waddr    = '0;
        bus.rf_wdata    = '0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.instr_ready = !reset;
                if (bus.instr_valid) state_d = ST_READ;
            end
            ST_READ: begin
                bus.rf_ra_addr = rn;
                bus.rf_rb_addr = rm;
                if (!cond_pass) begin
                    bus.done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (illegal_enc) begin
                    bus.illegal = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.alu_a      = bus.rf_a_data;
                bus.alu_b      = op_b;
                bus.alu_op     = (opc == OPC_MOV) ? ALU_OP_BYPASS : {1'b0, opc};
                bus.alu_s      = s_eff;
                bus.alu_out_en = 1'b1;
                state_d        = ST_WB;
            end
            ST_WB: begin
                bus.rf_we    = writes_rd(opc);
                bus.rf_waddr = rd;
                bus.rf_wdata = res_q;
                bus.done     = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Directed bench for arm_dp_sequencer with a behavioural regfile and ALU around it.
module tb_arm_dp_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arm_dp_sequencer_if #(.DW(32), .RF_AW(4)) bus ();

    arm_dp_sequencer #(.DW(32), .RF_AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Regfile: sync read, DUT writeback has priority over bench preloads.
    logic [31:0] rf [16];
    logic        rf_clr = 1'b1;
    logic        tb_wr = 1'b0;
    logic [3:0]  tb_waddr = '0;
    logic [31:0] tb_wdata = '0;

    always @(posedge clk) begin
        bus.rf_a_data <= rf[bus.rf_ra_addr];
        bus.rf_b_data <= rf[bus.rf_rb_addr];
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
        end else if (tb_wr) begin
            rf[tb_waddr] <= tb_wdata;
        end
    end

    // ALU model; logical ops report C=V=0 so flag preservation is observable.
    logic [32:0] sum;
    logic [31:0] ar, ab, r;
    logic [3:0]  f;
    always_comb begin
        ar = bus.alu_a;
        ab = bus.alu_b;
        sum = '0;
        r = '0;
        f = '0;
        case (bus.alu_op)
            5'b00100: begin
                sum = {1'b0, ar} + {1'b0, ab};
                r = sum[31:0];
                f = {r[31], r == 32'd0, sum[32], (ar[31] == ab[31]) && (r[31] != ar[31])};
            end
            5'b00010, 5'b01010: begin
                sum = {1'b0, ar} + {1'b0, ~ab} + 33'd1;
                r = sum[31:0];
                f = {r[31], r == 32'd0, sum[32], (ar[31] != ab[31]) && (r[31] != ar[31])};
            end
            5'b00000: begin
                r = ar & ab;
                f = {r[31], r == 32'd0, 2'b00};
            end
            5'b10000: begin
                r = ab;
                f = {r[31], r == 32'd0, bus.alu_flags[1:0]};
            end
            default: begin
                r = '0;
                f = '0;
            end
        endcase
        bus.alu_result    = bus.alu_out_en ? r : 'x;
        bus.alu_flags_out = bus.alu_out_en ? f : 'x;
    end

    int          done_c, ill_c, we_c, ex_c, busy_err, idle_alu_err;
    logic        ready0;
    logic [3:0]  w_addr;
    logic [31:0] w_data, ex_b;
    logic [4:0]  ex_op;
    logic        ex_s;

    task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    // Issue one instruction at the next negedge (cycle 0) and record the cycle of each event.
    task automatic run_instr(input logic [31:0] w);
        @(negedge clk);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        ready0 = bus.instr_ready;
        done_c = 0; ill_c = 0; we_c = 0; ex_c = 0; busy_err = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.instr = 32'hDEAD_BEEF;
            if (bus.instr_ready) busy_err++;
            if (!bus.alu_out_en && (bus.alu_a != 0 || bus.alu_b != 0 || bus.alu_op != 0)) idle_alu_err++;
            if (bus.alu_out_en && ex_c == 0) begin
                ex_c = k; ex_op = bus.alu_op; ex_s = bus.alu_s; ex_b = bus.alu_b;
            end
            if (bus.rf_we && we_c == 0) begin
                we_c = k; w_addr = bus.rf_waddr; w_data = bus.rf_wdata;
            end
            if (bus.done && done_c == 0) done_c = k;
            if (bus.illegal && ill_c == 0) ill_c = k;
            if (bus.done || bus.illegal) break;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.cpsr_flags !== 4'h0) begin tests_failed++; $display("FAIL reset_cpsr: got %h want 0", bus.cpsr_flags); end
        tests_run++; if ({bus.done, bus.illegal, bus.rf_we, bus.alu_out_en, bus.instr_ready} !== 5'b0) begin tests_failed++; $display("FAIL reset_outs: got %b want 00000", {bus.done, bus.illegal, bus.rf_we, bus.alu_out_en, bus.instr_ready}); end
        rf_clr = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
    endtask

    task automatic test_adds;
        set_reg(4'd0, 32'h7FFF_FFFF);
        set_reg(4'd1, 32'h0000_0001);
        run_instr(32'hE090_2001);
        tests_run++; if (ready0 !== 1'b1) begin tests_failed++; $display("FAIL adds_accept: got %b want 1", ready0); end
        tests_run++; if (ex_c !== 2 || ex_op !== 5'b00100 || ex_s !== 1'b1) begin tests_failed++; $display("FAIL adds_exec: got cyc %0d op %b s %b want 2 00100 1", ex_c, ex_op, ex_s); end
        tests_run++; if (we_c !== 3 || done_c !== 3) begin tests_failed++; $display("FAIL adds_timing: got we %0d done %0d want 3 3", we_c, done_c); end
        tests_run++; if (w_addr !== 4'd2 || w_data !== 32'h8000_0000) begin tests_failed++; $display("FAIL adds_wb: got r%0d=%h want r2=80000000", w_addr, w_data); end
        tests_run++; if (busy_err !== 0) begin tests_failed++; $display("FAIL adds_busy_ready: got %0d want 0", busy_err); end
        @(negedge clk);
        tests_run++; if (bus.cpsr_flags !== 4'b1001) begin tests_failed++; $display("FAIL adds_flags: got %b want 1001", bus.cpsr_flags); end
        tests_run++; if (rf[2] !== 32'h8000_0000) begin tests_failed++; $display("FAIL adds_r2: got %h want 80000000", rf[2]); end
        tests_run++; if (idle_alu_err !== 0) begin tests_failed++; $display("FAIL alu_idle_zero: got %0d want 0", idle_alu_err); end
    endtask

    task automatic test_back_to_back;
        set_reg(4'd0, 32'h0000_0005);
        set_reg(4'd3, 32'h0000_00AA);
        run_instr(32'hE350_0005);
        tests_run++; if (ex_op !== 5'b01010 || ex_b !== 32'd5) begin tests_failed++; $display("FAIL cmp_exec: got op %b b %h want 01010 5", ex_op, ex_b); end
        tests_run++; if (we_c !== 0 || done_c !== 3) begin tests_failed++; $display("FAIL cmp_timing: got we %0d done %0d want 0 3", we_c, done_c); end
        run_instr(32'h13A0_3001);
        tests_run++; if (ready0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b want 1", ready0); end
        tests_run++; if (done_c !== 1 || we_c !== 0 || ex_c !== 0) begin tests_failed++; $display("FAIL movne_skip: got done %0d we %0d ex %0d want 1 0 0", done_c, we_c, ex_c); end
        tests_run++; if (bus.cpsr_flags !== 4'b0110) begin tests_failed++; $display("FAIL cmp_flags: got %b want 0110", bus.cpsr_flags); end
        @(negedge clk);
        tests_run++; if (rf[3] !== 32'h0000_00AA) begin tests_failed++; $display("FAIL movne_r3: got %h want 000000aa", rf[3]); end
    endtask

    task automatic test_mov_imm;
        run_instr(32'hE3A0_44FF);
        tests_run++; if (ex_op !== 5'b10000 || ex_s !== 1'b0 || ex_b !== 32'hFF00_0000) begin tests_failed++; $display("FAIL mov_exec: got op %b s %b b %h want 10000 0 ff000000", ex_op, ex_s, ex_b); end
        tests_run++; if (we_c !== 3 || w_addr !== 4'd4 || w_data !== 32'hFF00_0000) begin tests_failed++; $display("FAIL mov_wb: got cyc %0d r%0d=%h want 3 r4=ff000000", we_c, w_addr, w_data); end
        @(negedge clk);
        tests_run++; if (bus.cpsr_flags !== 4'b0110) begin tests_failed++; $display("FAIL mov_flags: got %b want 0110", bus.cpsr_flags); end
    endtask

    task automatic test_ands_keep_cv;
        set_reg(4'd0, 32'h8000_0000);
        set_reg(4'd1, 32'hC000_0000);
        set_reg(4'd7, 32'h7FFF_FFFF);
        run_instr(32'hE090_6001);
        @(negedge clk);
        tests_run++; if (bus.cpsr_flags !== 4'b0011 || rf[6] !== 32'h4000_0000) begin tests_failed++; $display("FAIL adds_cv: got %b r6=%h want 0011 40000000", bus.cpsr_flags, rf[6]); end
        run_instr(32'hE010_5007);
        tests_run++; if (we_c !== 3 || w_addr !== 4'd5 || w_data !== 32'h0) begin tests_failed++; $display("FAIL ands_wb: got cyc %0d r%0d=%h want 3 r5=0", we_c, w_addr, w_data); end
        @(negedge clk);
        tests_run++; if (bus.cpsr_flags !== 4'b0111) begin tests_failed++; $display("FAIL ands_flags: got %b want 0111", bus.cpsr_flags); end
    endtask

    task automatic test_illegal;
        logic [31:0] enc [3];
        enc[0] = 32'hE082_1103;
        enc[1] = 32'hE590_1000;
        enc[2] = 32'hE280_F001;
        for (int i = 0; i < 3; i++) begin
            run_instr(enc[i]);
            tests_run++; if (ill_c !== 1 || done_c !== 0 || we_c !== 0 || ex_c !== 0) begin tests_failed++; $display("FAIL illegal_%0d: got ill %0d done %0d we %0d ex %0d want 1 0 0 0", i, ill_c, done_c, we_c, ex_c); end
        end
        @(negedge clk);
        tests_run++; if (bus.cpsr_flags !== 4'b0111) begin tests_failed++; $display("FAIL illegal_flags: got %b want 0111", bus.cpsr_flags); end
    endtask

    task automatic test_reset_mid;
        set_reg(4'd0, 32'h7FFF_FFFF);
        set_reg(4'd1, 32'h0000_0001);
        set_reg(4'd2, 32'h1234_5678);
        @(negedge clk);
        bus.instr = 32'hE090_2001;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.alu_out_en !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_exec: got %b want 1", bus.alu_out_en); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if ({bus.rf_we, bus.done, bus.instr_ready} !== 3'b000 || bus.cpsr_flags !== 4'h0) begin tests_failed++; $display("FAIL rst_mid_outs: got we/done/rdy %b cpsr %b want 000 0000", {bus.rf_we, bus.done, bus.instr_ready}, bus.cpsr_flags); end
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.instr_ready !== 1'b1 || rf[2] !== 32'h1234_5678) begin tests_failed++; $display("FAIL rst_mid_after: got rdy %b r2=%h want 1 12345678", bus.instr_ready, rf[2]); end
    endtask

    task automatic test_cond_after_reset;
        run_instr(32'h03A0_3001);
        tests_run++; if (done_c !== 1 || we_c !== 0) begin tests_failed++; $display("FAIL moveq_skip: got done %0d we %0d want 1 0", done_c, we_c); end
        run_instr(32'hF3A0_3001);
        tests_run++; if (done_c !== 1 || we_c !== 0 || ill_c !== 0) begin tests_failed++; $display("FAIL nv_skip: got done %0d we %0d ill %0d want 1 0 0", done_c, we_c, ill_c); end
        run_instr(32'hE3A0_3001);
        tests_run++; if (we_c !== 3 || w_addr !== 4'd3 || w_data !== 32'd1) begin tests_failed++; $display("FAIL moval_wb: got cyc %0d r%0d=%h want 3 r3=1", we_c, w_addr, w_data); end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        idle_alu_err = 0;
        test_reset;
        test_adds;
        test_back_to_back;
        test_mov_imm;
        test_ands_keep_cv;
        test_illegal;
        test_reset_mid;
        test_cond_after_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
